// File: rtl/me1_redirect_ctrl_t.sv
// me1_redirect_ctrl_t: ME1 branch-redirect controller.
// Decodes BEQ/BNE resolution, requests a fetch redirect over valid/ready,
// squashes IF/ID/EX on the wrong path, then holds IF squashed for
// DRAIN_CYCLES cycles to cover fetch responses already in flight.
// Optional feature macro: ME1_REDIRECT_STATS_EN builds saturating
// resolved/taken counters; without it both statistics ports read 0.
module me1_redirect_ctrl_t #(
    parameter int ADDR_W       = 32,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              me1_act,
    input  logic [2:0]        me1_branchop,
    input  logic              me1_zero,
    input  logic [ADDR_W-1:0] me1_target,
    output logic              redir_valid,
    output logic [ADDR_W-1:0] redir_pc,
    input  logic              redir_ready,
    output logic              flush_if,
    output logic              flush_id,
    output logic              flush_ex,
    output logic              busy,
    output logic [CNT_W-1:0]  stat_resolved,
    output logic [CNT_W-1:0]  stat_taken
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        drain_cnt;
    logic [3:0]        drain_cnt_nxt;
    logic [ADDR_W-1:0] redir_pc_nxt;
    logic              is_branch;
    logic              taken;

    // Same encoding as the ME1 pcsrc decode: op 3 = BEQ, op 2 = BNE.
    assign is_branch = (me1_branchop == 3'd2) | (me1_branchop == 3'd3);
    assign taken     = me1_act & (((me1_branchop == 3'd3) & me1_zero) |
                                  ((me1_branchop == 3'd2) & ~me1_zero));

    // Next-state logic; ME1 inputs only matter in IDLE since anything
    // in ME1 during REQ/DRAIN is already wrong-path.
    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        redir_pc_nxt  = redir_pc;
        case (state)
            IDLE: begin
                if (taken) begin
                    state_nxt     = REQ;
                    drain_cnt_nxt = DRAIN_INIT;
                    redir_pc_nxt  = me1_target;
                end
            end
            REQ: begin
                if (redir_valid & redir_ready) begin
                    state_nxt = (drain_cnt != 4'd0) ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                drain_cnt_nxt = drain_cnt - 4'd1;
                if (drain_cnt <= 4'd1) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register plus registered (Moore) outputs derived from the next state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            drain_cnt   <= 4'd0;
            redir_pc    <= '0;
            redir_valid <= 1'b0;
            flush_if    <= 1'b0;
            flush_id    <= 1'b0;
            flush_ex    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            drain_cnt   <= drain_cnt_nxt;
            redir_pc    <= redir_pc_nxt;
            redir_valid <= (state_nxt == REQ);
            flush_if    <= (state_nxt != IDLE);
            flush_id    <= (state == IDLE) && (state_nxt == REQ);
            flush_ex    <= (state == IDLE) && (state_nxt == REQ);
            busy        <= (state_nxt != IDLE);
        end
    end

`ifdef ME1_REDIRECT_STATS_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Saturating statistics: resolved branches seen in IDLE, accepted redirects.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stat_resolved <= '0;
            stat_taken    <= '0;
        end else begin
            if ((state == IDLE) && me1_act && is_branch) begin
                stat_resolved <= sat_inc(stat_resolved);
            end
            if ((state == IDLE) && (state_nxt == REQ)) begin
                stat_taken <= sat_inc(stat_taken);
            end
        end
    end
`else
    logic unused_is_branch;
    assign unused_is_branch = is_branch;
    assign stat_resolved    = '0;
    assign stat_taken       = '0;
`endif

endmodule

// File: doc/me1_redirect_ctrl_t.md
# me1_redirect_ctrl_t

Branch-redirect controller for the ME1 stage of the 4-stage RISC-V core. It takes the conditional-branch resolution from ME1 (branch op plus ALU zero flag), raises a redirect request to the fetch unit over a valid/ready handshake, and sequences the squash of wrong-path instructions in IF/ID/EX. Its redirect decode matches the ME1 stage's `s_me1_pcsrc` encoding exactly. It also owns the drain window that covers in-flight fetch responses.

## Interface
Parameters:
- `ADDR_W`, 32: PC/target width.
- `DRAIN_CYCLES`, 2: cycles to keep squashing IF after the redirect is accepted. Legal range 0..15.
- `CNT_W`, 16: statistics counter width.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  reset, asynchronous, active-low.
- `me1_act`  in  1  ME1 holds a valid instruction.
- `me1_branchop`  in  3  branch op.
  - 2: BNE.
  - 3: BEQ.
  - 0, 1, 4-7: no branch.
- `me1_zero`  in  1  ALU zero flag from EX.
- `me1_target`  in  ADDR_W  branch target address.
- `redir_valid`  out  1  redirect request to fetch.
- `redir_pc`  out  ADDR_W  redirect address; stable while `redir_valid` is high.
- `redir_ready`  in  1  fetch accepts the redirect.
- `flush_if`  out  1  squash the IF stage.
- `flush_id`  out  1  squash the ID stage.
- `flush_ex`  out  1  squash the EX stage.
- `busy`  out  1  state is not IDLE.
- `stat_resolved`  out  CNT_W  number of branches resolved.
- `stat_taken`  out  CNT_W  number of branches taken.

## Operation
- Combinational decode: `taken = me1_act & ((op==3 & me1_zero) | (op==2 & ~me1_zero))`.
- Decode is sampled only in IDLE. ME1 inputs are ignored in REQ and DRAIN, because anything in ME1 then is wrong-path.
- FSM states are IDLE, REQ and DRAIN.
- IDLE:
  - On `taken`: capture `me1_target` into `redir_pc`, load the drain counter with `DRAIN_CYCLES`, go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - `redir_valid`=1 and `flush_if`=1.
  - `flush_id` and `flush_ex` are high only in the first REQ cycle (one-cycle pulse).
  - On `redir_valid & redir_ready`: go to DRAIN if the counter is nonzero, else go to IDLE.
  - `redir_pc` does not change while in REQ.
- DRAIN:
  - `flush_if`=1 and `redir_valid`=0.
  - The counter decrements each cycle.
  - Leave for IDLE in the cycle the counter reads 1 (total of `DRAIN_CYCLES` DRAIN cycles).
- All outputs are registered (Moore). Reset values: state IDLE, all 1-bit outputs 0, `redir_pc`=0, counters 0.
- Reset asserted mid-operation: the FSM returns to IDLE immediately (asynchronously). A pending redirect is dropped without a handshake.

## Timing
- Branch resolved taken in cycle T (IDLE):
  - `redir_valid`, `flush_if`, `flush_id` and `flush_ex` are high in T+1.
- `redir_ready` already high in T+1:
  - Handshake completes in T+1.
  - DRAIN occupies T+2..T+1+DRAIN_CYCLES.
  - IDLE (`busy`=0) from T+2+DRAIN_CYCLES.
- `DRAIN_CYCLES`=0 with immediate ready: REQ lasts one cycle, IDLE in T+2. A taken branch in T+2 is accepted.
- `redir_ready` low: REQ holds indefinitely; `flush_id`/`flush_ex` are not re-pulsed.
- Not-taken branch: no outputs change; zero latency impact.
- A taken branch in the same cycle the FSM returns to IDLE is not seen; decode applies from the first IDLE cycle onward.

## Configuration
- Macro `ME1_REDIRECT_STATS_EN`.
- Defined:
  - `stat_resolved` increments in every IDLE cycle with `me1_act` and op in {2,3}.
  - `stat_taken` increments on each IDLE→REQ transition.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: the counters are not built; both ports are tied to 0. The port list is unchanged.

## Test plan
- Reset, then BEQ (op=3) with zero=1, target=0x0000_0100, ready=1 → in T+1: `redir_valid`=1, `redir_pc`=0x100, all three flushes=1. `flush_if` stays high T+2..T+3. `busy`=0 from T+4.
- BNE (op=2) with zero=1 → no redirect, all outputs stay 0. `stat_resolved`=1, `stat_taken`=0 (macro on).
- Taken branch, ready held low for 5 cycles → `redir_valid` and `redir_pc` stable for 6 cycles. `flush_id`/`flush_ex` high in the first cycle only. Accepted in the 6th cycle.
- While in REQ/DRAIN, drive taken BEQ with a different target → ignored; `redir_pc` unchanged; no second request.
- `RST` low during REQ → outputs 0 immediately. After release, op=0..7 sweep with both zero values → only op 2/3 redirect, per the decode.
- `CNT_W`=4, macro on, 20 taken branches → `stat_taken` saturates at 15.
